// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state encoding and read-during-write mode constants for ram_bank
package ram_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
endpackage

// File: rtl/ram_array.sv
// ram_array: storage with one write port and a registered read port (clk, rst active-low async, we/waddr/wdata, re/raddr -> rdata)
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  logic              w_fwd;
  assign w_fwd = (RDW_MODE == RDW_WRITE_FIRST) && we && (waddr == raddr);
  assign rdata = r_rdata;
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_rdata <= '0;
    else if (re) r_rdata <= w_fwd ? wdata : r_mem[raddr];
endmodule

// File: rtl/ram_bank.sv
// ram_bank: single-port RAM bank with clear sequencer (clk, rst active-low async, clr, wr_en, rd_en, addr, din -> out, out_valid, busy)
module ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_out_valid;
  logic              w_clear;
  logic              w_accept;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  assign w_clear   = r_state == CLEAR;
  assign w_accept  = !w_clear && !clr;
  assign w_we      = w_clear || (w_accept && wr_en);
  assign w_re      = w_accept && rd_en;
  assign w_waddr   = w_clear ? r_ptr : addr;
  assign w_wdata   = w_clear ? '0 : din;
  assign busy      = w_clear;
  assign out_valid = r_out_valid;
  ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (addr),
    .rdata (out)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= CLEAR;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_re;
      if (w_clear) begin
        r_ptr <= r_ptr + 1'b1;
        if (&r_ptr) r_state <= IDLE;
      end else if (clr) r_state <= CLEAR;
    end
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: randomized and directed checks of ram_bank against a behavioural model
module tb_ram_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] out0, out1;
  logic ov0, ov1, busy0, busy1;
  logic clr2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
  logic [5:0] addr2 = '0;
  logic [31:0] din2 = '0;
  logic [31:0] out2;
  logic ov2, busy2;
  ram_bank #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .din(din),
    .out(out0), .out_valid(ov0), .busy(busy0));
  ram_bank #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .din(din),
    .out(out1), .out_valid(ov1), .busy(busy1));
  ram_bank #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr2), .wr_en(wr2), .rd_en(rd2), .addr(addr2), .din(din2),
    .out(out2), .out_valid(ov2), .busy(busy2));
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [16];
  logic [7:0] e0 = '0, e1 = '0;
  logic eov = 1'b0;
  int clr_left = 0;
  task automatic step(input logic c, input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    clr = c; wr_en = w; rd_en = r; addr = a; din = d;
    @(posedge clk);
    if (clr_left > 0) begin
      clr_left--;
      eov = 1'b0;
    end else if (c) begin
      clr_left = 16;
      eov = 1'b0;
      foreach (mem[i]) mem[i] = '0;
    end else begin
      if (r) begin
        e0 = mem[a];
        e1 = w ? d : mem[a];
      end
      eov = r;
      if (w) mem[a] = d;
    end
    #1;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic test_reset;
    int n0, n1, n2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out0, out1, out2, ov0, ov1, ov2, busy0, busy1, busy2} !== {8'h00, 8'h00, 32'h0, 3'b000, 3'b111}) begin
      failures++;
      $display("FAIL reset_state: got out=%h/%h/%h ov=%b%b%b busy=%b%b%b want zeros, busy=111",
               out0, out1, out2, ov0, ov1, ov2, busy0, busy1, busy2);
    end
    @(negedge clk) rst = 1'b1;
    n0 = int'(busy0); n1 = int'(busy1); n2 = int'(busy2);
    repeat (70) begin
      @(posedge clk);
      #1;
      n0 += int'(busy0); n1 += int'(busy1); n2 += int'(busy2);
    end
    checks++;
    if (n0 != 16 || n1 != 16 || n2 != 64) begin
      failures++;
      $display("FAIL clear_duration: got busy cycles %0d/%0d/%0d want 16/16/64", n0, n1, n2);
    end
    foreach (mem[i]) mem[i] = '0;
    clr_left = 0; e0 = '0; e1 = '0; eov = 1'b0;
  endtask
  task automatic test_zero_reads;
    logic [3:0] al [3] = '{4'd0, 4'd3, 4'd15};
    foreach (al[k]) begin
      step(1'b0, 1'b0, 1'b1, al[k], 8'h00);
      checks++;
      if ({out0, out1, ov0, ov1, busy0} !== {8'h00, 8'h00, 2'b11, 1'b0}) begin
        failures++;
        $display("FAIL zero_read a=%0d: got out=%h/%h ov=%b%b busy=%b want 00/00 ov=11 busy=0",
                 al[k], out0, out1, ov0, ov1, busy0);
      end
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      checks++;
      if ({ov0, ov1} !== 2'b00) begin
        failures++;
        $display("FAIL zero_read_pulse a=%0d: got ov=%b%b want 00", al[k], ov0, ov1);
      end
    end
  endtask
  task automatic test_write_read;
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    checks++;
    if ({out0, out1, ov0, ov1} !== {8'hA5, 8'hA5, 2'b11}) begin
      failures++;
      $display("FAIL write_read: got out=%h/%h ov=%b%b want a5/a5 ov=11", out0, out1, ov0, ov1);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 4'd7, 8'h00);
    checks++;
    if ({out0, out1, ov0, ov1} !== {8'hA5, 8'hA5, 2'b00}) begin
      failures++;
      $display("FAIL out_hold: got out=%h/%h ov=%b%b want a5/a5 ov=00", out0, out1, ov0, ov1);
    end
  endtask
  task automatic test_rdw;
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h11);
    step(1'b0, 1'b1, 1'b1, 4'd3, 8'h22);
    checks++;
    if ({out0, out1, ov0, ov1} !== {8'h11, 8'h22, 2'b11}) begin
      failures++;
      $display("FAIL rdw_same_cycle: got out=%h/%h ov=%b%b want 11/22 ov=11", out0, out1, ov0, ov1);
    end
    step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    checks++;
    if ({out0, out1} !== {8'h22, 8'h22}) begin
      failures++;
      $display("FAIL rdw_later_read: got out=%h/%h want 22/22", out0, out1);
    end
  endtask
  task automatic test_clear;
    int bad;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'(i * 13 + 7));
    step(1'b1, 1'b1, 1'b0, 4'd5, 8'hEE);
    checks++;
    if ({busy0, busy1, ov0, ov1} !== 4'b1100) begin
      failures++;
      $display("FAIL clr_accept: got busy=%b%b ov=%b%b want busy=11 ov=00", busy0, busy1, ov0, ov1);
    end
    bad = 0;
    repeat (15) begin
      step(1'b0, 1'($urandom), 1'b1, 4'($urandom), 8'($urandom));
      if ({busy0, busy1, ov0, ov1} !== 4'b1100) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_ignore: got %0d bad cycles want 0", bad);
    end
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if ({busy0, busy1} !== 2'b00) begin
      failures++;
      $display("FAIL clr_end: got busy=%b%b want 00 after 16 cycles", busy0, busy1);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00);
      if ({out0, out1, ov0, ov1} !== {16'h0000, 2'b11}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clr_contents: got %0d nonzero reads want 0", bad);
    end
  endtask
  task automatic test_reset_mid;
    int n;
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 4'd1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (7) step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out0, out1, ov0, ov1, busy0, busy1} !== {16'h0000, 2'b00, 2'b11}) begin
      failures++;
      $display("FAIL async_reset: got out=%h/%h ov=%b%b busy=%b%b want 00/00 ov=00 busy=11",
               out0, out1, ov0, ov1, busy0, busy1);
    end
    @(negedge clk) rst = 1'b1;
    clr_left = 16; e0 = '0; e1 = '0; eov = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    n = int'(busy0);
    repeat (20) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      n += int'(busy0);
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL reset_restart: got busy cycles %0d want 16", n);
    end
  endtask
  task automatic test_random;
    int bad;
    logic c, w, r;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(59) == 0);
      w = 1'($urandom);
      r = 1'($urandom);
      step(c, w, r, 4'($urandom), 8'($urandom));
      checks++;
      if ({out0, out1, ov0, ov1, busy0, busy1} !== {e0, e1, eov, eov, clr_left != 0, clr_left != 0}) begin
        failures++;
        if (bad < 10)
          $display("FAIL random[%0d]: got out=%h/%h ov=%b%b busy=%b%b want %h/%h ov=%b busy=%b",
                   i, out0, out1, ov0, ov1, busy0, busy1, e0, e1, eov, clr_left != 0);
        bad++;
      end
    end
  endtask
  task automatic test_sweep;
    int n;
    int bad;
    logic [31:0] m2 [64];
    logic [31:0] ex;
    logic [5:0] a;
    logic w, r;
    n = 0;
    while (busy2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy2) begin
      failures++;
      $display("FAIL sweep_idle: got busy=1 after %0d cycles want 0", n);
    end
    foreach (m2[i]) m2[i] = '0;
    wr2 = 1'b1; addr2 = 6'd63; din2 = 32'hDEADBEEF;
    @(posedge clk); #1;
    wr2 = 1'b0; rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0;
    m2[63] = 32'hDEADBEEF;
    checks++;
    if ({out2, ov2} !== {32'hDEADBEEF, 1'b1}) begin
      failures++;
      $display("FAIL sweep_wr_rd: got out=%h ov=%b want deadbeef ov=1", out2, ov2);
    end
    rd2 = 1'b1; addr2 = 6'd0;
    @(posedge clk); #1;
    rd2 = 1'b0;
    checks++;
    if ({out2, ov2} !== {32'h0, 1'b1}) begin
      failures++;
      $display("FAIL sweep_addr0: got out=%h ov=%b want 00000000 ov=1", out2, ov2);
    end
    bad = 0;
    ex = out2;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom); r = 1'($urandom); a = 6'($urandom_range(7) + 56);
      wr2 = w; rd2 = r; addr2 = a; din2 = $urandom;
      @(posedge clk);
      if (r) ex = m2[a];
      if (w) m2[a] = din2;
      #1;
      wr2 = 1'b0; rd2 = 1'b0;
      if ({out2, ov2} !== {ex, r}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sweep_random: got %0d bad cycles want 0", bad);
    end
  endtask
  initial begin
    test_reset;
    test_zero_reads;
    test_write_read;
    test_rdw;
    test_clear;
    test_reset_mid;
    test_random;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised single-port synchronous RAM bank with registered read, a selectable read-during-write mode and a built-in clear sequencer. It zero-fills the array after every reset and on request. It is the generalised successor of the lab's 8×16 RAM. It sits between a datapath master, which issues single-cycle read and write requests, and on-chip storage.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- RDW_MODE, 0, read-during-write to the same cycle/address: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  request zero-fill of whole array (sampled when idle)
- wr_en  in  1  write request
- rd_en  in  1  read request
- addr  in  ADDR_W  word address for read and write
- din  in  DATA_W  write data
- out  out  DATA_W  registered read data
- out_valid  out  1  one-cycle pulse, out updated this cycle
- busy  out  1  clear sequence in progress; requests ignored

## Operation
- The FSM has two states, IDLE and CLEAR, plus an ADDR_W-bit clear pointer.
- Reset (rst low, async):
  - state = CLEAR, pointer = 0, busy = 1, out = 0, out_valid = 0.
  - The array itself is not reset; the clear sequence fills it.
- CLEAR state:
  - Each cycle writes 0 to mem[pointer], then the pointer increments.
  - On the cycle that writes address DEPTH-1, the next state is IDLE and the pointer wraps to 0.
  - wr_en, rd_en and clr are ignored. out holds its value and out_valid = 0.
- IDLE state, where clr has priority over everything:
  - clr = 1: next state is CLEAR. Any wr_en/rd_en in the same cycle is dropped and out_valid stays 0.
  - wr_en = 1: mem[addr] ← din at the clock edge.
  - rd_en = 1: out ← mem[addr] at the clock edge and out_valid = 1 in the following cycle. Otherwise out holds and out_valid = 0.
  - wr_en and rd_en both high (necessarily the same address):
    - RDW_MODE = 0: out = the old contents.
    - RDW_MODE = 1: out = din.
    - The write always happens in both modes.
- rst asserted mid-clear or mid-operation: the sequence restarts from pointer 0. Partially cleared contents are undefined until the new clear completes.
- Write data is stored exactly DATA_W bits wide; there is no truncation or extension logic.

## Timing
- Read latency is 1 cycle: request on edge N, out/out_valid valid after edge N (visible in cycle N+1).
- Write-to-read: a read issued the cycle after a write to the same address returns the new data.
- Clear duration:
  - Exactly DEPTH cycles with busy = 1 after rst deassertion (first edge with rst high writes address 0).
  - Also DEPTH cycles after an accepted clr.
- busy drops on the edge that writes address DEPTH-1. A request presented in the first cycle with busy = 0 is accepted.
- busy is a registered function of state, so there is no combinational path from inputs to outputs.

## Structure
- Package ram_pkg:
  - state encoding (IDLE, CLEAR)
  - RDW_MODE constants (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1)
- Sub-module ram_array holds the storage and the registered read port, parametrised by DATA_W, ADDR_W and RDW_MODE.
  - Inputs: we, waddr, wdata, re, raddr. Output: rdata.
  - ram_bank muxes the clear pointer/zero data onto the write port while in CLEAR.
- The top level holds the FSM, pointer, out_valid and busy.

## Test plan
- Reset release, defaults (DATA_W = 8, ADDR_W = 4) -> busy high for exactly 16 cycles, then low. Reads of addresses 0, 3 and 15 return 0x00 with out_valid pulsing one cycle each.
- Write 0xA5 to address 3, then rd_en at address 3 next cycle -> out = 0xA5 with out_valid one cycle after the read. out holds 0xA5 while rd_en is low.
- Address 3 holds 0x11; wr_en and rd_en with din = 0x22 -> out = 0x11 for RDW_MODE = 0, out = 0x22 for RDW_MODE = 1. A later read returns 0x22 in both modes.
- Fill addresses 0–15 with distinct data, pulse clr alongside wr_en at address 5 -> write dropped, busy for 16 cycles, all reads return 0x00. wr_en/rd_en pulses during busy have no effect and produce no out_valid.
- Assert rst after 7 clear cycles -> out = 0 and out_valid = 0 immediately (async). After release, busy lasts a full 16 cycles.
- Parameter sweep DATA_W = 32, ADDR_W = 6 -> 64-cycle clear. Write/read 0xDEADBEEF at address 63 returns the same value, and address 0 still reads 0.
